luma_frame_writer: RTL and testbench
====================================

# luma_frame_writer

Captures one window of an incoming pixel stream into a double-buffered 8-bit image BRAM, which a downstream sprite reader displays. Each RGB565 pixel is converted to an 8-bit code: luminance, or an RGB332 palette index when `LUMA_EN` is not defined. Pixels are written into the back half of a two-image memory. On frame completion the halves swap, and `pop_out` tells the reader which half is current.

## Interface
- `WIDTH`, 256, capture window width in pixels
- `HEIGHT`, 256, capture window height in pixels
- `ADDR_W`, `$clog2(2*WIDTH*HEIGHT)`, BRAM address width (derived; do not override)

Ports:
- `pixel_clk_in` in 1: the single clock
- `rst_in` in 1: synchronous reset, active-high
- `capture_in` in 1: one-cycle request to capture the next frame
- `continuous_in` in 1: when high, re-arm automatically after each frame
- `valid_in` in 1: pixel qualifier
- `pixel_in` in 16: RGB565 (R[15:11], G[10:5], B[4:0])
- `hcount_in` in 11: pixel x position
- `vcount_in` in 10: pixel y position
- `x_in` in 11: window origin x, sampled at arm
- `y_in` in 10: window origin y, sampled at arm
- `bram_addr_out` out `ADDR_W`: write address
- `bram_din_out` out 8: write data
- `bram_we_out` out 1: write enable
- `pop_out` out 1: front-buffer select; 1 = top half (offset 0), 0 = bottom half (offset `WIDTH*HEIGHT`)
- `busy_out` out 1: high in ARMED and CAPTURE
- `frame_done_out` out 1: one-cycle pulse after a completed swap
- `frame_err_out` out 1: sticky; set on an aborted frame, cleared by `capture_in`

## Operation
- FSM states: IDLE, ARMED, CAPTURE, DONE.
- IDLE to ARMED on `capture_in`. On this transition, latch `x_in` and `y_in` and clear `frame_err_out`.
- ARMED to CAPTURE on the first-pixel condition: `valid_in && hcount==x && vcount==y`. That pixel is accepted.
- In CAPTURE, a pixel is accepted when `valid_in` is high and it lies in [x, x+WIDTH) × [y, y+HEIGHT). All other pixels are ignored.
- CAPTURE to DONE when the pixel at (x+WIDTH-1, y+HEIGHT-1) is accepted.
- Abort: if the first-pixel condition recurs in CAPTURE before completion, set `frame_err_out` and stay in CAPTURE. Restart at that pixel without swapping.
- DONE lasts one cycle: toggle `pop_out` and pulse `frame_done_out`. Next state is ARMED if `continuous_in` is high, otherwise IDLE.
- `capture_in` outside IDLE is ignored.
- Address = (hcount−x) + (vcount−y)·WIDTH + (`pop_out` ? `WIDTH*HEIGHT` : 0). Writes always target the back buffer, i.e. the half opposite the one `pop_out` selects. Offsets are computed at full width; the sum is truncated to `ADDR_W`.
- Colour expansion uses bit replication: R8 = {r5, r5[4:2]}, G8 = {g6, g6[5:4]}, B8 = {b5, b5[4:2]}.
- Luma: Y = (77·R8 + 150·G8 + 29·B8) >> 8, using a 16-bit accumulator. The coefficients sum to 256, so Y never exceeds 255.

## Timing
- Two-stage write pipeline. A pixel accepted at cycle t appears on `bram_we_out`, `bram_addr_out` and `bram_din_out` at t+2.
- Stage 1 registers the products (or RGB332) and the offset address. Stage 2 registers the sum and the write strobe.
- Last pixel accepted at t gives: write at t+2, DONE at t+1, `pop_out` toggled and `frame_done_out` high at t+2. The front buffer's last write and the swap coincide; the reader sees the new half from t+3.
- Reset values: state IDLE, `pop_out`=1, `bram_we_out`=0, `bram_addr_out`=0, `bram_din_out`=0, `busy_out`=0, `frame_done_out`=0, `frame_err_out`=0.
- Reset also flushes the pipeline valid bits, so an in-flight write is dropped.
- Reset mid-capture gives no swap and no done pulse.

## Configuration
- `LUMA_EN` defined: data = Y as above; pipeline latency 2.
- `LUMA_EN` not defined: data = RGB332 {R8[7:5], G8[7:5], B8[7:6]}, which is a palette index into a 3-3-2 palette. Multipliers are omitted, and stage 1 carries the data unchanged so latency stays 2.

## Structure
- Shared package `luma_pkg`:
  - FSM state enum
  - luma coefficients `LUMA_R=77`, `LUMA_G=150`, `LUMA_B=29`
  - RGB565 field-slice constants
- Sub-module `rgb565_to_luma`: the two-stage conversion pipeline with valid passthrough, selected by `LUMA_EN`.
- The FSM, window check and address generation live in the top module.

## Test plan
All scenarios use WIDTH=4, HEIGHT=2, x=10, y=5, with `LUMA_EN` defined unless noted.
- Capture of white frame: `capture_in` then a full raster of 0xFFFF → 8 writes of 0xFF at addresses 8..15 (bottom half). `frame_done_out` pulses once, `pop_out` goes 1→0.
- Colour values:
  - pixel 0xF800 at (10,5) → din 0x4C at addr 8
  - pixel 0x07E0 → din 0x95
  - without `LUMA_EN`, 0xF800 → 0xE0
- Window clipping: valid pixels at (9,5), (14,5) and (10,7) → no `bram_we_out`. Pixel (13,6) → addr 15, two cycles after acceptance.
- Abort: restart condition at (10,5) after 3 accepted pixels → `frame_err_out`=1, no swap. The frame then completes normally with one done pulse.
- Continuous mode, `continuous_in`=1, three frames → `pop_out` goes 1,0,1,0 and write halves alternate. `capture_in` while busy is ignored.
- Reset mid-capture → all outputs at reset values the next cycle, no further writes, state IDLE.

Source files
------------

// File: rtl/luma_pkg.sv
// Shared types and constants for the luma frame writer.
// RGB565 field slices, luma weights, FSM state and colour expansion.
package luma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Bit replication keeps full-scale 565 at full-scale 888.
  function automatic rgb888_t expand565(input logic [15:0] p);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    rgb888_t    o;
    r5  = p[R_HI:R_LO];
    g6  = p[G_HI:G_LO];
    b5  = p[B_HI:B_LO];
    o.r = {r5, r5[4:2]};
    o.g = {g6, g6[5:4]};
    o.b = {b5, b5[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/rgb565_to_luma.sv
// Two-stage RGB565 to 8-bit code pipeline with valid/address passthrough.
// LUMA_EN defined: luminance; undefined: RGB332 palette index.
module rgb565_to_luma
  import luma_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  input  logic [15:0]       pixel_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              valid_out,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] addr_out
);

  rgb888_t px;
  assign px = expand565(pixel_in);

  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic              s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic [7:0]        s2_data_q, s2_data_d;

`ifdef LUMA_EN
  logic [15:0] pr_q, pr_d;
  logic [15:0] pg_q, pg_d;
  logic [15:0] pb_q, pb_d;
  logic [15:0] sum;
  logic        unused_sum;

  always_comb begin
    pr_d = pr_q;
    pg_d = pg_q;
    pb_d = pb_q;
    if (valid_in) begin
      pr_d = {8'd0, px.r} * 16'(LUMA_R);
      pg_d = {8'd0, px.g} * 16'(LUMA_G);
      pb_d = {8'd0, px.b} * 16'(LUMA_B);
    end
  end

  // Weights sum to 256, so the 16-bit total cannot overflow.
  assign sum        = pr_q + pg_q + pb_q;
  assign s2_data_d  = s1_valid_q ? sum[15:8] : s2_data_q;
  assign unused_sum = ^sum[7:0];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pr_q <= '0;
      pg_q <= '0;
      pb_q <= '0;
    end else begin
      pr_q <= pr_d;
      pg_q <= pg_d;
      pb_q <= pb_d;
    end
  end
`else
  logic [7:0] c332_q, c332_d;
  logic       unused_px;

  always_comb begin
    c332_d = c332_q;
    if (valid_in) begin
      c332_d = {px.r[7:5], px.g[7:5], px.b[7:6]};
    end
  end

  assign s2_data_d = s1_valid_q ? c332_q : s2_data_q;
  assign unused_px = ^{px.r[4:0], px.g[4:0], px.b[5:0]};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      c332_q <= '0;
    end else begin
      c332_q <= c332_d;
    end
  end
`endif

  always_comb begin
    s1_valid_d = valid_in;
    s1_addr_d  = valid_in ? addr_in : s1_addr_q;
    s2_valid_d = s1_valid_q;
    s2_addr_d  = s1_valid_q ? s1_addr_q : s2_addr_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign valid_out = s2_valid_q;
  assign data_out  = s2_data_q;
  assign addr_out  = s2_addr_q;

endmodule

// File: rtl/luma_frame_writer.sv
// Captures one pixel window into the back half of a double-buffered BRAM.
// Define LUMA_EN for luminance output; otherwise RGB332 palette indices.
module luma_frame_writer
  import luma_pkg::*;
#(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int ADDR_W = $clog2(2*WIDTH*HEIGHT)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic              capture_in,
  input  logic              continuous_in,
  input  logic              valid_in,
  input  logic [15:0]       pixel_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [10:0]       x_in,
  input  logic [9:0]        y_in,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic [7:0]        bram_din_out,
  output logic              bram_we_out,
  output logic              pop_out,
  output logic              busy_out,
  output logic              frame_done_out,
  output logic              frame_err_out
);

  state_e      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        pop_q, pop_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        accept;

  logic [11:0] x_end;
  logic [10:0] y_end;
  logic        in_win;
  logic        first_px;
  logic        last_px;

  assign x_end = {1'b0, x_q} + 12'(WIDTH);
  assign y_end = {1'b0, y_q} + 11'(HEIGHT);

  assign in_win = valid_in
               && (hcount_in >= x_q)
               && ({1'b0, hcount_in} < x_end)
               && (vcount_in >= y_q)
               && ({1'b0, vcount_in} < y_end);

  assign first_px = valid_in
                 && (hcount_in == x_q)
                 && (vcount_in == y_q);

  assign last_px = valid_in
                && ({1'b0, hcount_in} == x_end - 12'd1)
                && ({1'b0, vcount_in} == y_end - 11'd1);

  logic [10:0]       h_off;
  logic [9:0]        v_off;
  logic [31:0]       addr_full;
  logic [ADDR_W-1:0] wr_addr;
  logic              unused_addr;

  // pop_q selects the front half, so writes land in the other one.
  assign h_off     = hcount_in - x_q;
  assign v_off     = vcount_in - y_q;
  assign addr_full = 32'(h_off)
                   + 32'(v_off) * 32'(WIDTH)
                   + (pop_q ? 32'(WIDTH*HEIGHT) : 32'd0);
  assign wr_addr     = addr_full[ADDR_W-1:0];
  assign unused_addr = ^addr_full[31:ADDR_W];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    pop_d   = pop_q;
    done_d  = 1'b0;
    err_d   = err_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (capture_in) begin
          state_d = ST_ARMED;
          x_d     = x_in;
          y_d     = y_in;
          err_d   = 1'b0;
        end
      end
      ST_ARMED: begin
        if (first_px) begin
          accept  = 1'b1;
          state_d = last_px ? ST_DONE : ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (in_win) begin
          accept = 1'b1;
          if (last_px) begin
            state_d = ST_DONE;
          end else if (first_px) begin
            err_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        pop_d  = ~pop_q;
        done_d = 1'b1;
        if (continuous_in) begin
          state_d = ST_ARMED;
          x_d     = x_in;
          y_d     = y_in;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      pop_q   <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pop_q   <= pop_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  rgb565_to_luma #(
    .ADDR_W(ADDR_W)
  ) u_conv (
    .clk_in    (pixel_clk_in),
    .rst_in    (rst_in),
    .valid_in  (accept),
    .pixel_in  (pixel_in),
    .addr_in   (wr_addr),
    .valid_out (bram_we_out),
    .data_out  (bram_din_out),
    .addr_out  (bram_addr_out)
  );

  assign pop_out        = pop_q;
  assign busy_out       = (state_q == ST_ARMED)
                       || (state_q == ST_CAPTURE);
  assign frame_done_out = done_q;
  assign frame_err_out  = err_q;

endmodule

// File: tb/tb_luma_frame_writer.sv
// Directed bench for luma_frame_writer with a 4x2 window at (10,5).
// Expected data columns cover both the LUMA_EN and RGB332 builds.
module tb_luma_frame_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        capture = 1'b0;
  logic        continuous = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] pixel = '0;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [10:0] x_org = 11'd10;
  logic [9:0]  y_org = 10'd5;
  logic [3:0]  bram_addr;
  logic [7:0]  bram_din;
  logic        bram_we;
  logic        pop;
  logic        busy;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  luma_frame_writer #(
    .WIDTH (4),
    .HEIGHT(2)
  ) dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst),
    .capture_in    (capture),
    .continuous_in (continuous),
    .valid_in      (valid),
    .pixel_in      (pixel),
    .hcount_in     (hcount),
    .vcount_in     (vcount),
    .x_in          (x_org),
    .y_in          (y_org),
    .bram_addr_out (bram_addr),
    .bram_din_out  (bram_din),
    .bram_we_out   (bram_we),
    .pop_out       (pop),
    .busy_out      (busy),
    .frame_done_out(done),
    .frame_err_out (err)
  );

  typedef struct {
    int addr;
    int din;
  } wr_t;

  wr_t wq[$];
  int  done_cnt = 0;

  always @(negedge clk) begin
    if (bram_we === 1'b1)
      wq.push_back('{int'(bram_addr), int'(bram_din)});
    if (done === 1'b1)
      done_cnt++;
  end

  typedef struct {
    int          h;
    int          v;
    logic [15:0] p;
    logic        vld;
    logic        we;
    int          addr;
    int          d_luma;
    int          d_332;
    logic        dn;
  } vec_t;

  vec_t vec[10];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    valid = 1'b0;
    capture = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    wq.delete();
    done_cnt = 0;
  endtask

  task automatic drive(input int h, input int v,
                       input logic [15:0] p, input logic vld);
    hcount = 11'(h);
    vcount = 10'(v);
    pixel  = p;
    valid  = vld;
  endtask

  task automatic arm;
    capture = 1'b1;
    tick;
    capture = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    for (int i = 0; i < n; i++) tick;
  endtask

  task automatic win_frame(input bit cap_mid);
    for (int v = 0; v < 2; v++) begin
      for (int h = 0; h < 4; h++) begin
        drive(10 + h, 5 + v, 16'hFFFF, 1'b1);
        capture = cap_mid && (v == 0) && (h == 2);
        tick;
      end
    end
    capture = 1'b0;
    valid = 1'b0;
  endtask

  function automatic int exp_din(input vec_t t);
`ifdef LUMA_EN
    return t.d_luma;
`else
    return t.d_332;
`endif
  endfunction

  int bad;

  initial begin
    vec[0] = '{10, 5, 16'hF800, 1'b1, 1'b1, 8,  'h4C, 'hE0, 1'b0};
    vec[1] = '{11, 5, 16'h07E0, 1'b1, 1'b1, 9,  'h95, 'h1C, 1'b0};
    vec[2] = '{9,  5, 16'hFFFF, 1'b1, 1'b0, 0,  0,    0,    1'b0};
    vec[3] = '{14, 5, 16'hFFFF, 1'b1, 1'b0, 0,  0,    0,    1'b0};
    vec[4] = '{10, 7, 16'hFFFF, 1'b1, 1'b0, 0,  0,    0,    1'b0};
    vec[5] = '{12, 5, 16'hFFFF, 1'b0, 1'b0, 0,  0,    0,    1'b0};
    vec[6] = '{12, 5, 16'h001F, 1'b1, 1'b1, 10, 'h1C, 'h03, 1'b0};
    vec[7] = '{10, 6, 16'h0000, 1'b1, 1'b1, 12, 'h00, 'h00, 1'b0};
    vec[8] = '{11, 6, 16'h8410, 1'b1, 1'b1, 13, 'h82, 'h92, 1'b0};
    vec[9] = '{13, 6, 16'hFFFF, 1'b1, 1'b1, 15, 'hFF, 'hFF, 1'b1};

    // Reset state
    do_reset;
    chk("rst_we",   int'(bram_we),   0);
    chk("rst_addr", int'(bram_addr), 0);
    chk("rst_din",  int'(bram_din),  0);
    chk("rst_pop",  int'(pop),       1);
    chk("rst_busy", int'(busy),      0);
    chk("rst_done", int'(done),      0);
    chk("rst_err",  int'(err),       0);

    // Colour, clipping and latency vectors within one frame
    arm;
    chk("arm_busy", int'(busy), 1);
    for (int i = 0; i < 10; i++) begin
      drive(vec[i].h, vec[i].v, vec[i].p, vec[i].vld);
      tick;
      valid = 1'b0;
      chk($sformatf("v%0d_we_t1", i), int'(bram_we), 0);
      tick;
      chk($sformatf("v%0d_we", i), int'(bram_we), int'(vec[i].we));
      if (vec[i].we) begin
        chk($sformatf("v%0d_addr", i), int'(bram_addr), vec[i].addr);
        chk($sformatf("v%0d_din", i), int'(bram_din), exp_din(vec[i]));
      end
      chk($sformatf("v%0d_done", i), int'(done), int'(vec[i].dn));
    end
    chk("vec_pop", int'(pop), 0);
    tick;
    chk("vec_done_clr", int'(done), 0);
    chk("vec_busy", int'(busy), 0);

    // White frame over a wider raster
    do_reset;
    arm;
    for (int v = 4; v < 8; v++) begin
      for (int h = 8; h < 16; h++) begin
        drive(h, v, 16'hFFFF, 1'b1);
        tick;
      end
    end
    idle(4);
    chk("wf_count", wq.size(), 8);
    bad = 0;
    foreach (wq[i]) begin
      if (wq[i].addr != 8 + i || wq[i].din != 'hFF) bad++;
    end
    chk("wf_bad_writes", bad, 0);
    chk("wf_done_cnt", done_cnt, 1);
    chk("wf_pop", int'(pop), 0);
    chk("wf_busy", int'(busy), 0);

    // Abort after three accepted pixels, then full completion
    do_reset;
    arm;
    for (int h = 0; h < 3; h++) begin
      drive(10 + h, 5, 16'hFFFF, 1'b1);
      tick;
    end
    chk("ab_err_pre", int'(err), 0);
    drive(10, 5, 16'hFFFF, 1'b1);
    tick;
    chk("ab_err", int'(err), 1);
    chk("ab_busy", int'(busy), 1);
    idle(3);
    chk("ab_pop_hold", int'(pop), 1);
    chk("ab_done_none", done_cnt, 0);
    for (int k = 1; k < 8; k++) begin
      drive(10 + (k % 4), 5 + (k / 4), 16'hFFFF, 1'b1);
      tick;
    end
    idle(4);
    chk("ab_count", wq.size(), 11);
    bad = 0;
    foreach (wq[i]) begin
      if (wq[i].addr < 8 || wq[i].addr > 15) bad++;
    end
    chk("ab_half", bad, 0);
    chk("ab_done_cnt", done_cnt, 1);
    chk("ab_pop", int'(pop), 0);
    chk("ab_err_sticky", int'(err), 1);
    arm;
    chk("ab_err_clr", int'(err), 0);

    // Continuous mode, three frames, capture while busy
    do_reset;
    continuous = 1'b1;
    arm;
    win_frame(1'b0);
    idle(3);
    chk("ct_pop1", int'(pop), 0);
    win_frame(1'b1);
    idle(3);
    chk("ct_pop2", int'(pop), 1);
    win_frame(1'b0);
    idle(3);
    chk("ct_pop3", int'(pop), 0);
    chk("ct_count", wq.size(), 24);
    bad = 0;
    foreach (wq[i]) begin
      if (wq[i].addr != (((i / 8) % 2 == 0) ? 8 : 0) + (i % 8)) bad++;
    end
    chk("ct_halves", bad, 0);
    chk("ct_done_cnt", done_cnt, 3);
    chk("ct_busy", int'(busy), 1);
    continuous = 1'b0;

    // Reset mid-capture drops in-flight writes
    do_reset;
    arm;
    drive(10, 5, 16'h07E0, 1'b1);
    tick;
    drive(11, 5, 16'h07E0, 1'b1);
    tick;
    rst = 1'b1;
    valid = 1'b0;
    tick;
    rst = 1'b0;
    wq.delete();
    done_cnt = 0;
    chk("mr_we",   int'(bram_we),   0);
    chk("mr_addr", int'(bram_addr), 0);
    chk("mr_din",  int'(bram_din),  0);
    chk("mr_pop",  int'(pop),       1);
    chk("mr_busy", int'(busy),      0);
    chk("mr_done", int'(done),      0);
    chk("mr_err",  int'(err),       0);
    for (int k = 2; k < 8; k++) begin
      drive(10 + (k % 4), 5 + (k / 4), 16'hFFFF, 1'b1);
      tick;
    end
    idle(4);
    chk("mr_no_writes", wq.size(), 0);
    chk("mr_no_done", done_cnt, 0);
    chk("mr_pop_end", int'(pop), 1);
    chk("mr_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
